vend_ctrl: RTL and testbench
============================

# vend_ctrl

Parametrised multi-product vending controller: the successor to the single-product, fixed-price coffee FSM. It accumulates coin credit and accepts a product selection priced from a per-product table. It dispenses over a valid/ready handshake and returns change over a second valid/ready handshake. It supports cancel/refund and credit-overflow rejection, and sits between the coin-acceptor front end and the dispenser/change-hopper drivers.

## Interface
- N_PROD, 4, number of products (≥1)
- CW, 6, credit/price width in bits
- PRICES, {6'd15,6'd12,6'd9,6'd7}, packed price table; product i at [i*CW +: CW]; each price nonzero
- MAX_CREDIT, 31, maximum credit held (≤ 2^CW−1)
- TIMEOUT, 100, inactivity cycles before auto-refund (only with VEND_TIMEOUT_EN)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- coin_valid  in  1  one-cycle pulse per coin
- coin_value  in  CW  coin value; 0 is ignored
- sel_valid  in  1  one-cycle selection pulse
- sel_id  in  $clog2(N_PROD) (min 1)  product index
- cancel  in  1  one-cycle refund request
- vend_valid  out  1  dispense request
- vend_id  out  $clog2(N_PROD)  product being dispensed
- vend_ready  in  1  dispenser accepts
- change_valid  out  1  change request
- change_amt  out  CW  change amount
- change_ready  in  1  hopper accepts
- coin_reject  out  1  one-cycle pulse: coin returned, credit unchanged
- credit  out  CW  current credit
- busy  out  1  high in any state but IDLE

## Operation
- States: IDLE, CREDIT, VEND, CHANGE. All outputs are registered (Moore).
- Reset: state IDLE. credit, vend_valid, vend_id, change_valid, change_amt, coin_reject and busy are all 0. Reset mid-transaction discards credit with no refund.
- Credit sums are computed at CW+1 bits. A coin is accepted iff value≠0 and credit+value ≤ MAX_CREDIT; otherwise coin_reject pulses.
- IDLE: an accepted coin sets credit=value and moves to CREDIT. cancel and sel_valid are ignored.
- CREDIT, priority per cycle: cancel > coin > selection.
  - cancel: a coin in the same cycle is rejected. Go to CHANGE with change_amt=credit.
  - Accepted coin: credit += value. A selection in the same cycle is dropped.
  - sel_valid with sel_id<N_PROD and credit ≥ PRICES[sel_id]: latch vend_id, credit −= price, go to VEND.
  - Insufficient credit or sel_id ≥ N_PROD: selection ignored, state unchanged.
- VEND: vend_valid=1 with vend_id stable until vend_ready. On handshake: CHANGE if credit>0, else IDLE.
- CHANGE: change_valid=1, change_amt=credit, both stable until change_ready. On handshake: credit=0, go to IDLE.
- In VEND and CHANGE, every coin is rejected; cancel and sel_valid are ignored.

## Timing
- A coin accepted at edge t is reflected in credit from t+1. coin_reject is high during cycle t+1 only.
- A selection at edge t raises vend_valid from t+1 with credit already reduced.
- A vend handshake at edge t raises change_valid (or returns to IDLE) from t+1.
- A change handshake at edge t puts the block in IDLE with credit=0 from t+1.
- Best case, sel to IDLE with change: 3 cycles.
- Backpressure: indefinite wait in VEND/CHANGE; outputs hold.

## Configuration
- VEND_TIMEOUT_EN defined:
  - A counter runs in CREDIT and clears on every coin_valid, sel_valid or state entry.
  - When it reaches TIMEOUT, the block moves to CHANGE with full credit, as for cancel.
  - Counter width is $clog2(TIMEOUT+1).
- VEND_TIMEOUT_EN undefined: no counter; CREDIT is held indefinitely and TIMEOUT is unused.

## Test plan
- Coins 3,3,2 then sel_id=0 (price 7): credit 8; vend_valid with vend_id=0 next cycle; after vend_ready, change_valid with change_amt=1; after change_ready, IDLE with credit 0.
- Credit 30, coin 3: coin_reject pulse, credit stays 30. Then coin 1: credit 31.
- Credit 8, sel_id=3 (price 15): no vend, credit 8. Then cancel: change_amt=8, and a coin presented with cancel is rejected.
- Exact payment (coins summing to 9, sel_id=1) with vend_ready held low 5 cycles: vend_valid and vend_id stable throughout; after ready, returns to IDLE with no change cycle.
- Coin and sel_valid in the same cycle: coin counted, selection dropped. reset asserted in VEND: all outputs 0 immediately.
- With VEND_TIMEOUT_EN, TIMEOUT=100, credit 5 and no activity: change_valid with change_amt=5 after 100 cycles. Without the macro: still in CREDIT after 200 cycles.

Source files
------------

// File: rtl/vend_ctrl.sv
// Multi-product vending controller: coin credit, priced selection, dispense and change handshakes.
// Optional inactivity auto-refund is compiled in with `define VEND_TIMEOUT_EN.
module vend_ctrl #(
  parameter int                   N_PROD     = 4,
  parameter int                   CW         = 6,
  parameter logic [N_PROD*CW-1:0] PRICES     = {6'd15, 6'd12, 6'd9, 6'd7},
  parameter int                   MAX_CREDIT = 31,
  parameter int                   TIMEOUT    = 100,
  localparam int                  SW         = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          coin_valid,
  input  logic [CW-1:0] coin_value,
  input  logic          sel_valid,
  input  logic [SW-1:0] sel_id,
  input  logic          cancel,
  output logic          vend_valid,
  output logic [SW-1:0] vend_id,
  input  logic          vend_ready,
  output logic          change_valid,
  output logic [CW-1:0] change_amt,
  input  logic          change_ready,
  output logic          coin_reject,
  output logic [CW-1:0] credit,
  output logic          busy
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid and its payload hold steady until that edge, and ready may toggle freely.

  if (N_PROD < 1) begin : g_bad_nprod
    $error("vend_ctrl: N_PROD must be at least 1");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("vend_ctrl: TIMEOUT must be at least 1");
  end
  if (MAX_CREDIT > (2 ** CW) - 1) begin : g_bad_max
    $error("vend_ctrl: MAX_CREDIT does not fit in CW bits");
  end

  typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_CHANGE} state_t;

  localparam logic [CW:0] MAX_C = (CW + 1)'(MAX_CREDIT);

  state_t        r_state, w_state_nx;
  logic [CW-1:0] r_credit, w_credit_nx;
  logic [SW-1:0] r_vend_id, w_vend_id_nx;
  logic [CW-1:0] r_change_amt, w_change_amt_nx;
  logic          r_vend_valid, r_change_valid, r_coin_reject, r_busy;
  logic          w_reject_nx;

  logic [CW:0]   w_sum;
  logic          w_coin_nz, w_coin_ok;
  logic [CW-1:0] w_price;
  logic          w_sel_ok;
  logic          w_timeout;

  assign w_sum     = {1'b0, r_credit} + {1'b0, coin_value};
  assign w_coin_nz = coin_valid && (coin_value != '0);
  assign w_coin_ok = w_coin_nz && (w_sum <= MAX_C);

  // Table lookup by comparison so out-of-range ids simply fail to match.
  always_comb begin
    w_price  = '0;
    w_sel_ok = 1'b0;
    for (int i = 0; i < N_PROD; i++) begin
      if (sel_id == SW'(i)) begin
        w_price  = PRICES[i*CW +: CW];
        w_sel_ok = 1'b1;
      end
    end
  end

`ifdef VEND_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_cnt;

  assign w_timeout = (r_cnt == TW'(TIMEOUT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_state != S_CREDIT || coin_valid || sel_valid) begin
      r_cnt <= '0;
    end else if (!w_timeout) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nx      = r_state;
    w_credit_nx     = r_credit;
    w_vend_id_nx    = r_vend_id;
    w_change_amt_nx = r_change_amt;
    w_reject_nx     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_coin_ok) begin
          w_credit_nx = coin_value;
          w_state_nx  = S_CREDIT;
        end else begin
          w_reject_nx = w_coin_nz;
        end
      end
      S_CREDIT: begin
        if (cancel) begin
          w_reject_nx     = w_coin_nz;
          w_change_amt_nx = r_credit;
          w_state_nx      = S_CHANGE;
        end else if (w_coin_ok) begin
          w_credit_nx = w_sum[CW-1:0];
        end else begin
          w_reject_nx = w_coin_nz;
          if (sel_valid && w_sel_ok && (r_credit >= w_price)) begin
            w_vend_id_nx = sel_id;
            w_credit_nx  = r_credit - w_price;
            w_state_nx   = S_VEND;
          end else if (!coin_valid && !sel_valid && w_timeout) begin
            w_change_amt_nx = r_credit;
            w_state_nx      = S_CHANGE;
          end
        end
      end
      S_VEND: begin
        w_reject_nx = w_coin_nz;
        if (vend_ready) begin
          if (r_credit != '0) begin
            w_change_amt_nx = r_credit;
            w_state_nx      = S_CHANGE;
          end else begin
            w_state_nx = S_IDLE;
          end
        end
      end
      S_CHANGE: begin
        w_reject_nx = w_coin_nz;
        if (change_ready) begin
          w_credit_nx     = '0;
          w_change_amt_nx = '0;
          w_state_nx      = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Every output is a flop loaded from the next-state decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_credit       <= '0;
      r_vend_id      <= '0;
      r_change_amt   <= '0;
      r_vend_valid   <= 1'b0;
      r_change_valid <= 1'b0;
      r_coin_reject  <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state_nx;
      r_credit       <= w_credit_nx;
      r_vend_id      <= w_vend_id_nx;
      r_change_amt   <= w_change_amt_nx;
      r_vend_valid   <= (w_state_nx == S_VEND);
      r_change_valid <= (w_state_nx == S_CHANGE);
      r_coin_reject  <= w_reject_nx;
      r_busy         <= (w_state_nx != S_IDLE);
    end
  end

  assign vend_valid   = r_vend_valid;
  assign vend_id      = r_vend_id;
  assign change_valid = r_change_valid;
  assign change_amt   = r_change_amt;
  assign coin_reject  = r_coin_reject;
  assign credit       = r_credit;
  assign busy         = r_busy;

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed bench for vend_ctrl: inputs change on falling edges, outputs are checked on falling edges.
module tb_vend_ctrl;

  localparam int CW = 6;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          coin_valid;
  logic [CW-1:0] coin_value;
  logic          sel_valid;
  logic [SW-1:0] sel_id;
  logic          cancel;
  logic          vend_valid;
  logic [SW-1:0] vend_id;
  logic          vend_ready;
  logic          change_valid;
  logic [CW-1:0] change_amt;
  logic          change_ready;
  logic          coin_reject;
  logic [CW-1:0] credit;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  vend_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .coin_valid   (coin_valid),
    .coin_value   (coin_value),
    .sel_valid    (sel_valid),
    .sel_id       (sel_id),
    .cancel       (cancel),
    .vend_valid   (vend_valid),
    .vend_id      (vend_id),
    .vend_ready   (vend_ready),
    .change_valid (change_valid),
    .change_amt   (change_amt),
    .change_ready (change_ready),
    .coin_reject  (coin_reject),
    .credit       (credit),
    .busy         (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // driver tasks: each pulse spans one rising edge and returns on the following falling edge
  task automatic idle_inputs();
    coin_valid   = 1'b0;
    coin_value   = '0;
    sel_valid    = 1'b0;
    sel_id       = '0;
    cancel       = 1'b0;
    vend_ready   = 1'b0;
    change_ready = 1'b0;
  endtask

  task automatic coin(input int v);
    @(negedge clk);
    coin_valid = 1'b1;
    coin_value = CW'(v);
    @(negedge clk);
    coin_valid = 1'b0;
    coin_value = '0;
  endtask

  task automatic sel(input int id);
    @(negedge clk);
    sel_valid = 1'b1;
    sel_id    = SW'(id);
    @(negedge clk);
    sel_valid = 1'b0;
  endtask

  task automatic coin_and_sel(input int v, input int id);
    @(negedge clk);
    coin_valid = 1'b1;
    coin_value = CW'(v);
    sel_valid  = 1'b1;
    sel_id     = SW'(id);
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic cancel_with_coin(input int v);
    @(negedge clk);
    cancel     = 1'b1;
    coin_valid = (v != 0);
    coin_value = CW'(v);
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic ack_vend();
    @(negedge clk);
    vend_ready = 1'b1;
    @(negedge clk);
    vend_ready = 1'b0;
  endtask

  task automatic ack_change();
    @(negedge clk);
    change_ready = 1'b1;
    @(negedge clk);
    change_ready = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_credit"}, credit, 0);
    check({tag, "_vend_valid"}, vend_valid, 0);
    check({tag, "_vend_id"}, vend_id, 0);
    check({tag, "_change_valid"}, change_valid, 0);
    check({tag, "_change_amt"}, change_amt, 0);
    check({tag, "_coin_reject"}, coin_reject, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int waited;
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("post_rst");

    // IDLE ignores selection and cancel; an oversize coin bounces
    sel(0);
    check("idle_sel_busy", busy, 0);
    check("idle_sel_vend", vend_valid, 0);
    cancel_with_coin(0);
    check("idle_cancel_chg", change_valid, 0);
    coin(32);
    check("idle_ovf_reject", coin_reject, 1);
    check("idle_ovf_credit", credit, 0);
    check("idle_ovf_busy", busy, 0);

    // coins 3,3,2 then product 0 (price 7), change 1
    coin(3);
    check("c1_credit", credit, 3);
    check("c1_busy", busy, 1);
    coin(3);
    check("c2_credit", credit, 6);
    coin(2);
    check("c3_credit", credit, 8);
    sel(0);
    check("v0_valid", vend_valid, 1);
    check("v0_id", vend_id, 0);
    check("v0_credit", credit, 1);
    ack_vend();
    check("v0_done", vend_valid, 0);
    check("v0_chg_valid", change_valid, 1);
    check("v0_chg_amt", change_amt, 1);
    ack_change();
    check("v0_idle_chg", change_valid, 0);
    check("v0_idle_credit", credit, 0);
    check("v0_idle_busy", busy, 0);

    // overflow boundary at MAX_CREDIT = 31
    coin(30);
    check("m30_credit", credit, 30);
    coin(3);
    check("m33_reject", coin_reject, 1);
    check("m33_credit", credit, 30);
    @(negedge clk);
    check("m33_reject_pulse", coin_reject, 0);
    coin(1);
    check("m31_reject", coin_reject, 0);
    check("m31_credit", credit, 31);
    cancel_with_coin(0);
    check("m31_chg_amt", change_amt, 31);
    ack_change();
    check("m31_idle", busy, 0);

    // insufficient credit, then cancel with a coin in the same cycle
    coin(8);
    sel(3);
    check("ins_vend", vend_valid, 0);
    check("ins_credit", credit, 8);
    check("ins_busy", busy, 1);
    cancel_with_coin(2);
    check("cn_reject", coin_reject, 1);
    check("cn_chg_valid", change_valid, 1);
    check("cn_chg_amt", change_amt, 8);
    coin(1);
    check("chg_coin_reject", coin_reject, 1);
    check("chg_amt_hold", change_amt, 8);
    ack_change();
    check("cn_idle_credit", credit, 0);
    check("cn_idle_busy", busy, 0);

    // exact payment with five cycles of dispenser backpressure
    coin(4);
    coin(5);
    sel(1);
    check("ex_valid", vend_valid, 1);
    check("ex_id", vend_id, 1);
    check("ex_credit", credit, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", vend_valid, 1);
      check("bp_id", vend_id, 1);
    end
    ack_vend();
    check("ex_vend_done", vend_valid, 0);
    check("ex_no_change", change_valid, 0);
    check("ex_idle", busy, 0);

    // coin and selection together: coin wins, selection dropped
    coin(5);
    coin_and_sel(2, 0);
    check("cs_credit", credit, 7);
    check("cs_vend", vend_valid, 0);
    sel(0);
    check("cs_vend2", vend_valid, 1);
    check("cs_credit2", credit, 0);
    // asynchronous reset in VEND
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_all_zero("rst_vend");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_vend_idle", busy, 0);

    // inactivity
    coin(5);
`ifdef VEND_TIMEOUT_EN
    waited = 0;
    while (!change_valid && waited < 150) begin
      @(negedge clk);
      waited++;
    end
    check("to_fired", change_valid, 1);
    check("to_amt", change_amt, 5);
    check("to_not_early", (waited >= 99), 1);
    ack_change();
    check("to_idle", busy, 0);
`else
    waited = 0;
    repeat (200) begin
      @(negedge clk);
      waited++;
    end
    check("nto_waited", waited, 200);
    check("nto_busy", busy, 1);
    check("nto_chg", change_valid, 0);
    check("nto_credit", credit, 5);
    cancel_with_coin(0);
    check("nto_cancel_amt", change_amt, 5);
    ack_change();
    check("nto_idle", busy, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
